tagged_vector_normalizer: RTL

- Sequential fixed-point vector normaliser that sits directly upstream of the tagged-normalized FIFO.
- Accepts one tagged signed 3-component vector at a time and computes its length with a bit-serial integer square root.
- Divides each component by that length using three parallel restoring dividers.
- Writes the tagged unit vector into the FIFO, honouring the FIFO's full flag so the FIFO never overflows.

---
 rtl/tagged_vector_normalizer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tagged_vector_normalizer.sv
// tagged_vector_normalizer
//
// Normalises one tagged, signed 3-component fixed-point vector at a time and
// writes the tagged unit vector into a downstream FIFO.
//   SQSUM : len2 = x^2 + y^2 + z^2 (unsigned, 2*DATA_W bits, Q.2FRAC)
//   SQRT  : len  = floor(sqrt(len2)), restoring, one root bit per cycle
//   DIV   : q_c  = floor((|c| << FRAC) / len), three restoring dividers in
//           lockstep, one quotient bit per cycle
//   EMIT  : waits for !fifo_full, then registers the signed result and
//           pulses out_write for one cycle
//
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE; in_valid while busy
// is ignored. Downstream, out_write is a one-cycle strobe that is never
// issued in a cycle whose edge saw fifo_full high.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_x, in_y, in_z      signed QI.FRAC components
//   in_tag                tag travelling with the vector
//   fifo_full             downstream FIFO full, sampled only in EMIT
//   out_write             one-cycle FIFO write strobe
//   out_x, out_y, out_z   signed normalised components (same Q format)
//   out_tag               tag of the emitted vector
//   out_degenerate        emitted vector had zero length
//   busy                  high in any state other than IDLE
//   dbg_state_o           current FSM state, for observation only

`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module tagged_vector_normalizer #(
    parameter int DATA_W   = 32,
    parameter int FRAC     = 16,
    parameter int TAG_SIZE = `TAG_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_y,
    input  logic [DATA_W-1:0]   in_z,
    input  logic [TAG_SIZE-1:0] in_tag,
    input  logic                fifo_full,
    output logic                out_write,
    output logic [DATA_W-1:0]   out_x,
    output logic [DATA_W-1:0]   out_y,
    output logic [DATA_W-1:0]   out_z,
    output logic [TAG_SIZE-1:0] out_tag,
    output logic                out_degenerate,
    output logic                busy,
    output logic [2:0]          dbg_state_o
);

    localparam int DIV_W  = DATA_W + FRAC;      // dividend / quotient width
    localparam int SREM_W = DATA_W + 2;         // sqrt remainder register
    localparam int CNT_W  = $clog2(DIV_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQSUM = 3'd1,
        S_SQRT  = 3'd2,
        S_DIV   = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [2:0]                  sign_q;
    logic [TAG_SIZE-1:0]         tag_q;
    // Holds {|c|, FRAC zeros} as dividend; the quotient shifts in at the LSB,
    // so after DIV_W steps the register holds q_c.
    logic [2:0][DIV_W-1:0]       div_q;
    logic [2:0][DATA_W-1:0]      drem_q;
    logic [2*DATA_W-1:0]         rad_q;
    logic [SREM_W-1:0]           srem_q;
    logic [DATA_W-1:0]           root_q;

    // Combinational step results
    logic [2:0][DATA_W-1:0]      in_vec;
    logic [2:0][DATA_W-1:0]      abs_d;
    logic [2:0][2*DATA_W-1:0]    mag_ext;
    logic [2*DATA_W-1:0]         len2_d;
    logic [SREM_W+1:0]           srem_sh;
    logic [SREM_W+1:0]           sqrt_trial;
    logic                        sqrt_ge;
    logic [SREM_W-1:0]           srem_d;
    logic [DATA_W-1:0]           root_d;
    logic [DATA_W:0]             divisor;
    logic                        degen;
    logic [2:0][DATA_W:0]        drem_sh;
    logic [2:0]                  div_ge;
    logic [2:0][DATA_W-1:0]      drem_d;
    logic [2:0][DIV_W-1:0]       div_d;
    logic [2:0][DATA_W-1:0]      quo;
    logic [2:0][DATA_W-1:0]      res_d;

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    // Input magnitudes; |-2^(DATA_W-1)| wraps to 2^(DATA_W-1), which is the
    // correct unsigned magnitude.
    always_comb begin
        in_vec[0] = in_x;
        in_vec[1] = in_y;
        in_vec[2] = in_z;
        for (int i = 0; i < 3; i++) begin
            abs_d[i] = in_vec[i][DATA_W-1] ? (~in_vec[i] + DATA_W'(1)) : in_vec[i];
        end
    end

    // Sum of squares over the magnitudes parked in the top of div_q.
    always_comb begin
        len2_d = '0;
        for (int i = 0; i < 3; i++) begin
            mag_ext[i] = {{DATA_W{1'b0}}, div_q[i][DIV_W-1 -: DATA_W]};
            len2_d     = len2_d + mag_ext[i] * mag_ext[i];
        end
    end

    // Restoring square root step: bring down the next two radicand bits and
    // try to subtract 4*root + 1.
    always_comb begin
        srem_sh    = {srem_q, rad_q[2*DATA_W-1 -: 2]};
        sqrt_trial = {2'b00, root_q, 2'b01};
        sqrt_ge    = (srem_sh >= sqrt_trial);
        srem_d     = sqrt_ge ? SREM_W'(srem_sh - sqrt_trial) : srem_sh[SREM_W-1:0];
        root_d     = {root_q[DATA_W-2:0], sqrt_ge};
    end

    // Restoring divider step; a zero length forces every quotient bit to 0
    // instead of dividing by zero.
    always_comb begin
        divisor = {1'b0, root_q};
        degen   = (root_q == '0);
        for (int i = 0; i < 3; i++) begin
            drem_sh[i] = {drem_q[i], div_q[i][DIV_W-1]};
            div_ge[i]  = !degen && (drem_sh[i] >= divisor);
            drem_d[i]  = div_ge[i] ? DATA_W'(drem_sh[i] - divisor) : drem_sh[i][DATA_W-1:0];
            div_d[i]   = {div_q[i][DIV_W-2:0], div_ge[i]};
        end
    end

    // Re-apply the sign; q <= 2^FRAC so the low DATA_W bits hold it exactly,
    // and negating zero yields zero.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            quo[i]   = div_q[i][DATA_W-1:0];
            res_d[i] = sign_q[i] ? (~quo[i] + DATA_W'(1)) : quo[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            sign_q         <= '0;
            tag_q          <= '0;
            div_q          <= '0;
            drem_q         <= '0;
            rad_q          <= '0;
            srem_q         <= '0;
            root_q         <= '0;
            out_write      <= 1'b0;
            out_x          <= '0;
            out_y          <= '0;
            out_z          <= '0;
            out_tag        <= '0;
            out_degenerate <= 1'b0;
        end else begin
            out_write <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            div_q[i]  <= {abs_d[i], {FRAC{1'b0}}};
                            sign_q[i] <= in_vec[i][DATA_W-1];
                        end
                        drem_q  <= '0;
                        tag_q   <= in_tag;
                        cnt_q   <= '0;
                        state_q <= S_SQSUM;
                    end
                end
                S_SQSUM: begin
                    rad_q   <= len2_d;
                    srem_q  <= '0;
                    root_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= S_SQRT;
                end
                S_SQRT: begin
                    rad_q  <= {rad_q[2*DATA_W-3:0], 2'b00};
                    srem_q <= srem_d;
                    root_q <= root_d;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    div_q  <= div_d;
                    drem_q <= drem_d;
                    if (cnt_q == CNT_W'(DIV_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_EMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (!fifo_full) begin
                        out_x          <= res_d[0];
                        out_y          <= res_d[1];
                        out_z          <= res_d[2];
                        out_tag        <= tag_q;
                        out_degenerate <= degen;
                        out_write      <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
